// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=4 convolutional encoder and its Viterbi decoder.
// Both sides must use the same generator polynomials.
package viterbi_pkg;
  localparam int K          = 4;
  localparam int NUM_STATES = 8;
  localparam int TAIL_LEN   = K - 1;

  localparam logic [3:0] G0_DEF = 4'b1111;
  localparam logic [3:0] G1_DEF = 4'b1101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    TAIL  = 2'd2,
    DRAIN = 2'd3
  } enc_state_t;

  // Window ordering is {u, s[2], s[1], s[0]}.
  function automatic logic conv_parity(input logic [3:0] w, input logic [3:0] g);
    return ^(w & g);
  endfunction
endpackage

// File: rtl/conv_enc_core.sv
// Encoder trellis state: 3-bit shift register plus the two generator parities.
// sym reflects the symbol produced if u is shifted in on this cycle.
module conv_enc_core
  import viterbi_pkg::*;
#(
  parameter logic [3:0] G0 = G0_DEF,
  parameter logic [3:0] G1 = G1_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       advance,
  input  logic       u,
  output logic [1:0] sym
);
  logic [2:0] s_r;
  logic [3:0] w_s;

  assign w_s = {u, s_r};
  assign sym = {conv_parity(w_s, G0), conv_parity(w_s, G1)};

  // Shift register: newest bit enters at s[2].
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_r <= 3'b000;
    end else if (clear) begin
      s_r <= 3'b000;
    end else if (advance) begin
      s_r <= {u, s_r[2:1]};
    end else begin
      s_r <= s_r;
    end
  end
endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 K=4 convolutional encoder with per-frame zero tail and a
// single-entry output register using valid/ready on both sides.
module conv_encoder
  import viterbi_pkg::*;
#(
  parameter int         FRAME_LEN = 1024,
  parameter logic [3:0] G0        = G0_DEF,
  parameter logic [3:0] G1        = G1_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       start,
  input  logic       d_in,
  input  logic       d_in_valid,
  output logic       d_in_ready,
  output logic [1:0] d_out,
  output logic       d_out_valid,
  input  logic       d_out_ready,
  output logic       d_out_last,
  output logic       busy
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] FRAME_MAX = CNT_W'(FRAME_LEN);
  localparam logic [1:0]       TAIL_LAST = 2'(TAIL_LEN - 1);

  enc_state_t       state_r, state_nxt_s;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [1:0]       tail_cnt_r;
  logic [1:0]       d_out_r;
  logic             d_out_valid_r, d_out_last_r, busy_r;
  logic             load_ok_s, load_s, u_s, clr_s, last_s, in_ready_s;
  logic [1:0]       sym_s;

  assign load_ok_s   = !d_out_valid_r || d_out_ready;
  assign d_in_ready  = in_ready_s && enable && rst;
  assign d_out       = d_out_r;
  assign d_out_valid = d_out_valid_r;
  assign d_out_last  = d_out_last_r;
  assign busy        = busy_r;

  conv_enc_core #(.G0(G0), .G1(G1)) u_core (
    .clk     (clk),
    .rst     (rst),
    .clear   (clr_s || !enable),
    .advance (load_s),
    .u       (u_s),
    .sym     (sym_s)
  );

  // Next-state and load decisions for the frame sequencer.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    u_s         = 1'b0;
    clr_s       = 1'b0;
    last_s      = 1'b0;
    in_ready_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = DATA;
          clr_s       = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DATA: begin
        in_ready_s = load_ok_s;
        if (d_in_valid && load_ok_s) begin
          load_s = 1'b1;
          u_s    = d_in;
          if (bit_cnt_r == LAST_BIT) begin
            state_nxt_s = TAIL;
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      TAIL: begin
        if (load_ok_s) begin
          load_s = 1'b1;
          if (tail_cnt_r == TAIL_LAST) begin
            last_s      = 1'b1;
            state_nxt_s = DRAIN;
          end else begin
            state_nxt_s = TAIL;
          end
        end else begin
          state_nxt_s = TAIL;
        end
      end
      DRAIN: begin
        if (d_out_valid_r && d_out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, saturating counters and the single-entry output register.
  always_ff @(posedge clk) begin
    if (!rst || !enable) begin
      state_r       <= IDLE;
      bit_cnt_r     <= '0;
      tail_cnt_r    <= 2'd0;
      d_out_r       <= 2'b00;
      d_out_valid_r <= 1'b0;
      d_out_last_r  <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (clr_s) begin
        bit_cnt_r  <= '0;
        tail_cnt_r <= 2'd0;
        busy_r     <= 1'b1;
      end else if (load_s && state_r == DATA && bit_cnt_r != FRAME_MAX) begin
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
      end else if (load_s && state_r == TAIL && tail_cnt_r != 2'd3) begin
        tail_cnt_r <= tail_cnt_r + 2'd1;
      end else if (state_r == DRAIN && d_out_valid_r && d_out_ready) begin
        busy_r <= 1'b0;
      end
      if (load_s) begin
        d_out_r       <= sym_s;
        d_out_valid_r <= 1'b1;
        d_out_last_r  <= last_s;
      end else if (d_out_valid_r && d_out_ready) begin
        d_out_valid_r <= 1'b0;
        d_out_last_r  <= 1'b0;
      end
    end
  end
endmodule
